mips_irq_ctl: RTL and testbench

- Parametrised N-source interrupt controller sitting between device blocks and the mips_core irq_i/irq_addr inputs.
- Generalises the single registered irq_req/irq_addr pair to N maskable sources with per-source edge/level mode and fixed priority (lowest index wins).
- Drives a programmable vector address and holds a request/acknowledge/end-of-interrupt handshake with the core.
- Software-visible through the cop-style word bus used by mips_dvc.

---
 rtl/mips_irq_ctl_pkg.sv | 34 +++
 rtl/mips_irq_ctl_sync_edge.sv | 30 +++
 rtl/mips_irq_ctl.sv | 176 +++++++++++++++++
 tb/tb_mips_irq_ctl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_irq_ctl_pkg.sv
// Shared constants for the N-source interrupt controller: register decode
// indices (byte address bits [4:2]), FSM state encoding and the priority
// encoder helper.
package mips_irq_ctl_pkg;

    localparam logic [2:0] IRQ_PEND  = 3'd0;  // 0x00
    localparam logic [2:0] IRQ_MASK  = 3'd1;  // 0x04
    localparam logic [2:0] IRQ_MODE  = 3'd2;  // 0x08
    localparam logic [2:0] IRQ_VBASE = 3'd3;  // 0x0C
    localparam logic [2:0] IRQ_CUR   = 3'd4;  // 0x10
    localparam logic [2:0] IRQ_EOI   = 3'd5;  // 0x14

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_SVC  = 2'd2
    } irq_state_t;

    // Index of the lowest set bit (lowest index has highest priority).
    // Returns 0 when the vector is empty; callers only use it when nonzero.
    function automatic logic [4:0] first_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[4:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mips_irq_ctl_sync_edge.sv
// Per-source input conditioning: SYNC_STAGES-deep synchroniser for an
// asynchronous interrupt line plus a rising-edge detector on its output.
module mips_irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_src,
    output logic o_lvl,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the raw line through the synchroniser and remember the last synchronised level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_lvl  = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/mips_irq_ctl.sv
// N-source interrupt controller in front of the mips_core irq inputs.
// Maskable sources with edge/level mode, fixed lowest-index priority, a
// programmable vector base and a request/ack/EOI handshake with the core.
module mips_irq_ctl
    import mips_irq_ctl_pkg::*;
#(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int VEC_SHIFT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_i,
    input  logic             sel_i,
    input  logic             wr_i,
    input  logic [4:0]       addr_i,
    input  logic [31:0]      din_i,
    output logic [31:0]      dout_o,
    output logic             irq_req_o,
    output logic [31:0]      irq_addr_o,
    input  logic             irq_ack_i
);

    // Bits at or above N_SRC do not exist and always read 0.
    localparam logic [31:0] SRC_MASK = (N_SRC >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << N_SRC) - 32'd1);

    logic [31:0] r_pend, r_mask, r_mode, r_vbase, r_dout, r_irq_addr;
    logic [4:0]  r_id;
    logic        r_irq_req;
    irq_state_t  r_state;

    logic [31:0] w_lvl, w_rise, w_w1c, w_ack_clr, w_pend_nxt, w_eligible;
    logic [31:0] w_rdata, w_cur, w_vec, w_irq_addr_nxt;
    logic [4:0]  w_first, w_id_nxt;
    logic        w_wr, w_rd, w_eoi, w_irq_req_nxt;
    logic [2:0]  w_reg;
    irq_state_t  w_state_nxt;
    logic        w_unused_addr;

    genvar g;
    generate
        for (g = 0; g < 32; g++) begin : g_src
            if (g < N_SRC) begin : g_on
                mips_irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
                    .i_clk   (clk),
                    .i_rst_n (rst),
                    .i_src   (src_i[g]),
                    .o_lvl   (w_lvl[g]),
                    .o_rise  (w_rise[g])
                );
            end else begin : g_off
                assign w_lvl[g]  = 1'b0;
                assign w_rise[g] = 1'b0;
            end
        end
    endgenerate

    assign w_unused_addr = ^addr_i[1:0];
    assign w_wr          = sel_i & wr_i;
    assign w_rd          = sel_i & ~wr_i;
    assign w_reg         = addr_i[4:2];
    assign w_eoi         = w_wr && (w_reg == IRQ_EOI);
    assign w_eligible    = r_pend & r_mask;
    assign w_first       = first_set(w_eligible);
    assign w_vec         = r_vbase + ({27'd0, w_first} << VEC_SHIFT);
    assign w_cur         = {(r_state == IRQ_SVC), 26'd0, r_id};

    // Next pending vector: edge bits set on rise (set beats W1C/ack clear), level bits follow the line.
    always_comb begin
        w_w1c     = 32'd0;
        w_ack_clr = 32'd0;
        if (w_wr && (w_reg == IRQ_PEND)) begin
            w_w1c = din_i & SRC_MASK;
        end else begin
            w_w1c = 32'd0;
        end
        if ((r_state == IRQ_REQ) && irq_ack_i) begin
            w_ack_clr = 32'd1 << r_id;
        end else begin
            w_ack_clr = 32'd0;
        end
        w_pend_nxt = ((r_mode & (w_rise | (r_pend & ~(w_w1c | w_ack_clr))))
                     | (~r_mode & w_lvl)) & SRC_MASK;
    end

    // Register read multiplexer; unused and write-only offsets read as 0.
    always_comb begin
        w_rdata = 32'd0;
        case (w_reg)
            IRQ_PEND:  w_rdata = r_pend;
            IRQ_MASK:  w_rdata = r_mask;
            IRQ_MODE:  w_rdata = r_mode;
            IRQ_VBASE: w_rdata = r_vbase;
            IRQ_CUR:   w_rdata = w_cur;
            default:   w_rdata = 32'd0;
        endcase
    end

    // Software-visible registers and the registered read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend  <= 32'd0;
            r_mask  <= 32'd0;
            r_mode  <= 32'd0;
            r_vbase <= 32'd0;
            r_dout  <= 32'd0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_wr && (w_reg == IRQ_MASK))  r_mask  <= din_i & SRC_MASK;
            if (w_wr && (w_reg == IRQ_MODE))  r_mode  <= din_i & SRC_MASK;
            if (w_wr && (w_reg == IRQ_VBASE)) r_vbase <= din_i;
            if (w_rd)                         r_dout  <= w_rdata;
        end
    end

    // Handshake next-state logic; the vector and id are latched only on IDLE->REQ so they stay stable in REQ.
    always_comb begin
        w_state_nxt    = r_state;
        w_irq_req_nxt  = 1'b0;
        w_irq_addr_nxt = r_irq_addr;
        w_id_nxt       = r_id;
        case (r_state)
            IRQ_IDLE: begin
                if (|w_eligible) begin
                    w_state_nxt    = IRQ_REQ;
                    w_irq_req_nxt  = 1'b1;
                    w_id_nxt       = w_first;
                    w_irq_addr_nxt = w_vec;
                end else begin
                    w_state_nxt    = IRQ_IDLE;
                end
            end
            IRQ_REQ: begin
                if (irq_ack_i) begin
                    w_state_nxt = IRQ_SVC;
                end else if (!w_eligible[r_id]) begin
                    w_state_nxt = IRQ_IDLE;
                end else begin
                    w_state_nxt   = IRQ_REQ;
                    w_irq_req_nxt = 1'b1;
                end
            end
            IRQ_SVC: begin
                if (w_eoi) begin
                    w_state_nxt = IRQ_IDLE;
                end else begin
                    w_state_nxt = IRQ_SVC;
                end
            end
            default: begin
                w_state_nxt = IRQ_IDLE;
            end
        endcase
    end

    // Handshake state and registered request outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IRQ_IDLE;
            r_irq_req  <= 1'b0;
            r_irq_addr <= 32'd0;
            r_id       <= 5'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_irq_req  <= w_irq_req_nxt;
            r_irq_addr <= w_irq_addr_nxt;
            r_id       <= w_id_nxt;
        end
    end

    assign dout_o     = r_dout;
    assign irq_req_o  = r_irq_req;
    assign irq_addr_o = r_irq_addr;

endmodule

// File: tb/tb_mips_irq_ctl.sv
// Self-checking bench for mips_irq_ctl with default parameters: a
// behavioural model compared every cycle plus directed literal checks.
module tb_mips_irq_ctl;

    localparam int N  = 8;
    localparam int SS = 2;
    localparam int VS = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_SVC  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] src_i = '0;
    logic         sel_i = 1'b0;
    logic         wr_i = 1'b0;
    logic [4:0]   addr_i = 5'd0;
    logic [31:0]  din_i = 32'd0;
    logic [31:0]  dout_o;
    logic         irq_req_o;
    logic [31:0]  irq_addr_o;
    logic         irq_ack_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    mips_irq_ctl #(.N_SRC(N), .SYNC_STAGES(SS), .VEC_SHIFT(VS)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_i      (src_i),
        .sel_i      (sel_i),
        .wr_i       (wr_i),
        .addr_i     (addr_i),
        .din_i      (din_i),
        .dout_o     (dout_o),
        .irq_req_o  (irq_req_o),
        .irq_addr_o (irq_addr_o),
        .irq_ack_i  (irq_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_h [0:SS];      // m_h[k]: src_i as sampled k+1 edges ago
    logic [N-1:0] m_pend, m_mask, m_mode;
    logic [31:0]  m_vbase, m_addr, m_dout;
    logic [4:0]   m_id;
    int           m_phase;

    function automatic logic [31:0] mread(input logic [2:0] r);
        case (r)
            3'd0:    return {24'd0, m_pend};
            3'd1:    return {24'd0, m_mask};
            3'd2:    return {24'd0, m_mode};
            3'd3:    return m_vbase;
            3'd4:    return {(m_phase == PH_SVC), 26'd0, m_id};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin : model
        logic [N-1:0] lvl_v, rise_v, clr_v, elig_v, np_v;
        logic [2:0]   r_v;
        logic         wr_v;
        int           low_v;
        if (!rst) begin
            for (int k = 0; k <= SS; k++) m_h[k] <= '0;
            m_pend <= '0; m_mask <= '0; m_mode <= '0;
            m_vbase <= 32'd0; m_addr <= 32'd0; m_dout <= 32'd0;
            m_id <= 5'd0; m_phase <= PH_IDLE;
        end else begin
            lvl_v  = m_h[SS-1];
            rise_v = lvl_v & ~m_h[SS];
            for (int k = SS; k >= 1; k--) m_h[k] <= m_h[k-1];
            m_h[0] <= src_i;
            wr_v = sel_i && wr_i;
            r_v  = addr_i[4:2];
            if (sel_i && !wr_i) m_dout <= mread(r_v);
            if (wr_v && r_v == 3'd1) m_mask  <= din_i[N-1:0];
            if (wr_v && r_v == 3'd2) m_mode  <= din_i[N-1:0];
            if (wr_v && r_v == 3'd3) m_vbase <= din_i;
            clr_v = (wr_v && r_v == 3'd0) ? din_i[N-1:0] : '0;
            if (m_phase == PH_REQ && irq_ack_i) clr_v[m_id] = 1'b1;
            for (int i = 0; i < N; i++)
                np_v[i] = m_mode[i] ? (rise_v[i] | (m_pend[i] & ~clr_v[i])) : lvl_v[i];
            m_pend <= np_v;
            elig_v = m_pend & m_mask;
            low_v = -1;
            for (int i = N - 1; i >= 0; i--) if (elig_v[i]) low_v = i;
            if (m_phase == PH_IDLE && low_v >= 0) begin
                m_phase <= PH_REQ;
                m_id    <= low_v[4:0];
                m_addr  <= m_vbase + 32'(low_v) * (32'd1 << VS);
            end else if (m_phase == PH_REQ && irq_ack_i) begin
                m_phase <= PH_SVC;
            end else if (m_phase == PH_REQ && !elig_v[m_id]) begin
                m_phase <= PH_IDLE;
            end else if (m_phase == PH_SVC && wr_v && r_v == 3'd5) begin
                m_phase <= PH_IDLE;
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            check("req", {31'd0, irq_req_o}, {31'd0, (m_phase == PH_REQ)});
            if (m_phase == PH_REQ) check("vec", irq_addr_o, m_addr);
            check("dout", dout_o, m_dout);
        end
    end

    // ---------------- stimulus helpers (call at a negedge) ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        sel_i = 1'b1; wr_i = 1'b1; addr_i = a; din_i = d;
        @(negedge clk);
        sel_i = 1'b0; wr_i = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
        sel_i = 1'b1; wr_i = 1'b0; addr_i = a;
        @(negedge clk);
        sel_i = 1'b0;
        check(nm, dout_o, exp);
    endtask

    task automatic wait_req(input string nm);
        int k;
        k = 0;
        while (!irq_req_o && k < 12) begin
            cyc();
            k++;
        end
        check(nm, {31'd0, irq_req_o}, 32'd1);
    endtask

    task automatic ack();
        irq_ack_i = 1'b1;
        cyc();
        irq_ack_i = 1'b0;
    endtask

    initial begin
        // Reset held with source activity: no request may appear.
        for (int i = 0; i < 4; i++) begin
            src_i = 8'hFF;
            #10;
            src_i = 8'h00;
            #10;
        end
        check("rst_req", {31'd0, irq_req_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        ack();  // stray ack in IDLE
        for (int r = 0; r < 8; r++) rd_chk("rst_read", 5'(r * 4), 32'd0);

        // Single edge source 2.
        wr_reg(5'h04, 32'h04);
        wr_reg(5'h08, 32'h04);
        wr_reg(5'h0C, 32'h100);
        src_i = 8'h04;
        cyc(); cyc();
        src_i = 8'h00;
        cyc();
        check("lat_req_early", {31'd0, irq_req_o}, 32'd0);
        cyc();
        check("lat_req", {31'd0, irq_req_o}, 32'd1);
        check("lat_vec", irq_addr_o, 32'h120);
        ack();
        rd_chk("single_pend", 5'h00, 32'd0);
        rd_chk("single_cur", 5'h10, 32'h8000_0002);
        ack();  // stray ack in SERVICE
        wr_reg(5'h14, 32'hFFFF_FFFF);
        rd_chk("eoi_cur", 5'h10, 32'h0000_0002);

        // Out-of-range bits and reserved offsets.
        wr_reg(5'h04, 32'hFFFF_FFFF);
        rd_chk("mask_width", 5'h04, 32'h0000_00FF);
        wr_reg(5'h18, 32'hDEAD_BEEF);
        rd_chk("rsvd_read", 5'h18, 32'd0);

        // Priority: sources 5 and 1 together.
        wr_reg(5'h08, 32'hFF);
        src_i = 8'h22;
        cyc(); cyc();
        src_i = 8'h00;
        wait_req("prio_req1");
        check("prio_vec1", irq_addr_o, 32'h110);
        ack();
        rd_chk("prio_cur1", 5'h10, 32'h8000_0001);
        wr_reg(5'h14, 32'd0);
        wait_req("prio_req5");
        check("prio_vec5", irq_addr_o, 32'h150);
        ack();
        wr_reg(5'h14, 32'd0);

        // Level source 3 withdrawn before ack.
        wr_reg(5'h08, 32'h00);
        wr_reg(5'h04, 32'h08);
        src_i = 8'h08;
        wait_req("lvl_req");
        check("lvl_vec", irq_addr_o, 32'h130);
        src_i = 8'h00;
        for (int k = 0; k < 8 && irq_req_o; k++) cyc();
        check("lvl_drop", {31'd0, irq_req_o}, 32'd0);
        rd_chk("lvl_cur", 5'h10, 32'h0000_0003);
        rd_chk("lvl_pend", 5'h00, 32'd0);

        // Set/clear collision on source 0 (masked off so the FSM stays idle).
        wr_reg(5'h04, 32'h00);
        wr_reg(5'h08, 32'h01);
        src_i = 8'h01;
        for (int k = 0; k < 5; k++) cyc();
        rd_chk("col_pend_set", 5'h00, 32'h01);
        src_i = 8'h00;
        for (int k = 0; k < 4; k++) cyc();
        wr_reg(5'h00, 32'h01);
        rd_chk("col_w1c", 5'h00, 32'h00);
        src_i = 8'h01;
        cyc(); cyc();
        wr_reg(5'h00, 32'h01);
        rd_chk("col_set_wins", 5'h00, 32'h01);

        // Asynchronous reset while in SERVICE.
        wr_reg(5'h04, 32'h01);
        wait_req("svc_req");
        check("svc_vec", irq_addr_o, 32'h100);
        ack();
        rd_chk("svc_cur", 5'h10, 32'h8000_0000);
        #2 rst = 1'b0;
        src_i = 8'h00;
        #1;
        check("arst_req", {31'd0, irq_req_o}, 32'd0);
        check("arst_dout", dout_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        rd_chk("arst_cur", 5'h10, 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                cyc();
                seen = seen | irq_req_o;
            end
            check("arst_no_req", {31'd0, seen}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
